// File: rtl/cfu_mac_requant_if.sv
// CFU command/response bus between the CPU (master) and the MAC/requant datapath (slave).
// Latency: none, signal bundle only.
// Backpressure: cmd_ready gates commands, rsp_ready gates responses.
interface cfu_mac_requant_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_mac_requant.sv
// Banked int8 SIMD MAC with pipelined TFLite-style requantise/clamp on the CFU bus.
// Latency: 1 cycle for CLEAR/MAC/SET_*/READ, 5 cycles for REQUANT (BIAS, MUL, SHIFT, CLAMP, RESP).
// Backpressure: response held while rsp_ready=0; no new command accepted until it drains.
// Build option: define CFU_MAC_SATURATE_EN to saturate the accumulate and acc+bias adds.
module cfu_mac_requant #(
    parameter int NUM_ACC      = 4,
    parameter int INPUT_OFFSET = 128,
    parameter int ACT_MIN      = -128,
    parameter int ACT_MAX      = 127
) (
    input logic             clk,
    input logic             reset,
    cfu_mac_requant_if.slave bus
);
    localparam int BW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    localparam logic [6:0] OP_CLEAR     = 7'd0;
    localparam logic [6:0] OP_MAC       = 7'd1;
    localparam logic [6:0] OP_SET_BIAS  = 7'd2;
    localparam logic [6:0] OP_SET_QUANT = 7'd3;
    localparam logic [6:0] OP_REQUANT   = 7'd4;
    localparam logic [6:0] OP_READ      = 7'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MUL, S_SHIFT, S_CLAMP, S_RESP
    } state_t;

    state_t             state;
    logic signed [31:0] acc  [NUM_ACC];
    logic signed [31:0] bias [NUM_ACC];
    logic signed [31:0] out_offset;
    logic signed [31:0] mult;
    logic signed [31:0] shift;
    logic [BW-1:0]      rq_bank;
    logic signed [31:0] sum_q;
    logic signed [63:0] prod_q;
    logic signed [31:0] shr_q;

    logic [6:0]         op;
    logic [BW-1:0]      bank;
    logic               accept;

    // Bank select wraps onto the implemented banks so any 3-bit select is legal.
    function automatic logic [BW-1:0] bank_of(input logic [2:0] sel);
        int idx;
        idx = int'({29'd0, sel}) % NUM_ACC;
        return BW'(idx);
    endfunction

    // 32-bit add that either wraps or saturates depending on the build.
    function automatic logic signed [31:0] add32(input logic signed [31:0] x,
                                                 input logic signed [31:0] y);
`ifdef CFU_MAC_SATURATE_EN
        logic signed [32:0] s;
        s = {x[31], x} + {y[31], y};
        if (s[32] != s[31])
            return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return s[31:0];
`else
        return x + y;
`endif
    endfunction

    assign op            = bus.cmd_payload_function_id[9:3];
    assign bank          = bank_of(bus.cmd_payload_function_id[2:0]);
    assign bus.cmd_ready = (state == S_IDLE && !bus.rsp_valid) ||
                           (state == S_RESP && bus.rsp_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    logic signed [8:0]  a_lane;
    logic signed [7:0]  b_lane;
    logic signed [16:0] prod_lane;
    logic signed [18:0] dot;
    logic signed [31:0] mac_sum;

    // Four-lane dot product of offset activations and weights, added into the selected bank.
    always_comb begin
        a_lane    = '0;
        b_lane    = '0;
        prod_lane = '0;
        dot       = '0;
        for (int i = 0; i < 4; i++) begin
            a_lane    = {bus.cmd_payload_inputs_0[8*i+7], bus.cmd_payload_inputs_0[8*i +: 8]}
                        + 9'(INPUT_OFFSET);
            b_lane    = bus.cmd_payload_inputs_1[8*i +: 8];
            prod_lane = $signed({{8{a_lane[8]}}, a_lane}) * $signed({{9{b_lane[7]}}, b_lane});
            dot       = dot + {{2{prod_lane[16]}}, prod_lane};
        end
        mac_sum = add32(acc[bank], {{13{dot[18]}}, dot});
    end

    logic signed [33:0] t_full;
    logic [5:0]         tsh;
    logic signed [31:0] acc_bias;
    logic signed [63:0] prod_next;
    logic signed [63:0] rounded;
    logic signed [31:0] shr_next;
    logic signed [31:0] biased;
    logic signed [31:0] clamp_next;

    // Requantise stage logic: each pipeline register feeds the next stage's combinational step.
    always_comb begin
        t_full = 34'sd31 - {{2{shift[31]}}, shift};
        if (t_full < 34'sd1)
            tsh = 6'd1;
        else if (t_full > 34'sd62)
            tsh = 6'd62;
        else
            tsh = t_full[5:0];
        acc_bias  = add32(acc[rq_bank], bias[rq_bank]);
        prod_next = $signed({{32{sum_q[31]}}, sum_q}) * $signed({{32{mult[31]}}, mult});
        rounded   = prod_q + (64'sd1 << (tsh - 6'd1));
        shr_next  = 32'(rounded >>> tsh);
        biased    = shr_q + out_offset;
        if (biased < ACT_MIN)
            clamp_next = 32'(ACT_MIN);
        else if (biased > ACT_MAX)
            clamp_next = 32'(ACT_MAX);
        else
            clamp_next = biased;
    end

    // Control FSM plus all architectural and pipeline state; responses are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= S_IDLE;
            bus.rsp_valid             <= 1'b0;
            bus.rsp_payload_outputs_0 <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i]  <= '0;
                bias[i] <= '0;
            end
            out_offset <= '0;
            mult       <= '0;
            shift      <= '0;
            rq_bank    <= '0;
            sum_q      <= '0;
            prod_q     <= '0;
            shr_q      <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        state                     <= S_RESP;
                        bus.rsp_valid             <= 1'b1;
                        bus.rsp_payload_outputs_0 <= '0;
                        case (op)
                            OP_CLEAR: acc[bank] <= '0;
                            OP_MAC: begin
                                acc[bank]                 <= mac_sum;
                                bus.rsp_payload_outputs_0 <= mac_sum;
                            end
                            OP_SET_BIAS: begin
                                bias[bank] <= bus.cmd_payload_inputs_0;
                                out_offset <= bus.cmd_payload_inputs_1;
                            end
                            OP_SET_QUANT: begin
                                mult  <= bus.cmd_payload_inputs_0;
                                shift <= bus.cmd_payload_inputs_1;
                            end
                            OP_REQUANT: begin
                                state         <= S_BIAS;
                                bus.rsp_valid <= 1'b0;
                                rq_bank       <= bank;
                            end
                            OP_READ: bus.rsp_payload_outputs_0 <= acc[bank];
                            default: ;
                        endcase
                    end else if (state == S_RESP && bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                S_BIAS: begin
                    sum_q <= acc_bias;
                    state <= S_MUL;
                end
                S_MUL: begin
                    prod_q <= prod_next;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    shr_q <= shr_next;
                    state <= S_CLAMP;
                end
                S_CLAMP: begin
                    bus.rsp_payload_outputs_0 <= clamp_next;
                    bus.rsp_valid             <= 1'b1;
                    state                     <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_mac_requant.sv
// Bench for cfu_mac_requant: directed scenarios plus randomized commands against a reference model.
// Latency: checks 1-cycle and 5-cycle response timing.
// Backpressure: exercises rsp_ready held low and back-to-back acceptance.
module tb_cfu_mac_requant;
    localparam int NA      = 4;
    localparam int IN_OFF  = 128;
    localparam int A_MIN   = -128;
    localparam int A_MAX   = 127;

    logic clk;
    logic reset;
    cfu_mac_requant_if bus ();

    cfu_mac_requant dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference state
    int macc  [NA];
    int mbias [NA];
    int moff;
    int mmult;
    int mshift;

    function automatic int m_add(input int x, input int y);
        longint t;
        t = longint'(x) + longint'(y);
`ifdef CFU_MAC_SATURATE_EN
        if (t > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (t < -64'sd2147483648) return 32'h8000_0000;
`endif
        return int'(t);
    endfunction

    function automatic int m_dot(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte ab;
        byte bb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            s  = s + (int'(ab) + IN_OFF) * int'(bb);
        end
        return s;
    endfunction

    function automatic int m_requant(input int acc, input int bs, input int mu,
                                     input int sh, input int off);
        longint s;
        longint p;
        longint t;
        int     r;
        s = longint'(m_add(acc, bs));
        t = 64'sd31 - longint'(sh);
        if (t < 1)  t = 1;
        if (t > 62) t = 62;
        p = s * longint'(mu);
        p = (p + (longint'(1) << (t - 1))) >>> t;
        r = int'(p) + off;
        if (r < A_MIN) r = A_MIN;
        if (r > A_MAX) r = A_MAX;
        return r;
    endfunction

    task automatic model(input int op, input int bk, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] e);
        int k;
        k = bk % NA;
        e = '0;
        case (op)
            0: macc[k] = 0;
            1: begin macc[k] = m_add(macc[k], m_dot(a, b)); e = macc[k]; end
            2: begin mbias[k] = a; moff = b; end
            3: begin mmult = a; mshift = b; end
            4: e = m_requant(macc[k], mbias[k], mmult, mshift, moff);
            5: e = macc[k];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            macc[i]  = 0;
            mbias[i] = 0;
        end
        moff = 0; mmult = 0; mshift = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives one command; returns response, latency (-1 on timeout) and cycles spent waiting for cmd_ready.
    task automatic do_cmd(input int op, input int bk, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output int waits);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = {op[6:0], bk[2:0]};
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        waits = 0;
        while (!bus.cmd_ready && waits < 50) begin @(posedge clk); #1; waits++; end
        @(posedge clk); #1;
        bus.cmd_valid               = 1'b0;
        bus.cmd_payload_function_id = 10'($urandom);
        bus.cmd_payload_inputs_0    = $urandom;
        bus.cmd_payload_inputs_1    = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!bus.rsp_valid || waits >= 50) lat = -1;
        r = bus.rsp_payload_outputs_0;
    endtask

    task automatic test_reset();
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        total++; if (bus.rsp_payload_outputs_0 !== 32'd0) begin bad++; $display("FAIL reset_payload got=%h exp=0", bus.rsp_payload_outputs_0); end
    endtask

    task automatic test_mac_read();
        logic [31:0] r, e;
        int lat, w;
        model(0, 0, 0, 0, e);
        do_cmd(0, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd0 || lat !== 1) begin bad++; $display("FAIL clear got=%h lat=%0d exp=0 lat=1", r, lat); end
        model(1, 0, 32'h0, 32'h0101_0101, e);
        do_cmd(1, 0, 32'h0, 32'h0101_0101, r, lat, w);
        total++; if (r !== 32'd512 || lat !== 1) begin bad++; $display("FAIL mac512 got=%h lat=%0d exp=200 lat=1", r, lat); end
        model(5, 0, 0, 0, e);
        do_cmd(5, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd512) begin bad++; $display("FAIL read512 got=%h exp=200", r); end
    endtask

    task automatic test_requant();
        logic [31:0] r, e;
        int lat, w;
        model(2, 0, 32'h0, -32'sd128, e);
        do_cmd(2, 0, 32'h0, -32'sd128, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL set_bias got=%h exp=0", r); end
        model(3, 0, 32'h4000_0000, 32'h0, e);
        do_cmd(3, 0, 32'h4000_0000, 32'h0, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL set_quant got=%h exp=0", r); end
        model(4, 0, 0, 0, e);
        do_cmd(4, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd127) begin bad++; $display("FAIL requant_clamp got=%0d exp=127", $signed(r)); end
        total++; if (lat !== 5) begin bad++; $display("FAIL requant_latency got=%0d exp=5", lat); end
        model(2, 0, 32'h0, -32'sd200, e);
        do_cmd(2, 0, 32'h0, -32'sd200, r, lat, w);
        model(4, 0, 0, 0, e);
        do_cmd(4, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd56) begin bad++; $display("FAIL requant_off200 got=%0d exp=56", $signed(r)); end
        model(5, 0, 0, 0, e);
        do_cmd(5, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd512) begin bad++; $display("FAIL requant_keeps_acc got=%h exp=200", r); end
    endtask

    task automatic test_banks();
        logic [31:0] r, e;
        int lat, w;
        model(0, 1, 0, 0, e); do_cmd(0, 1, 32'h0, 32'h0, r, lat, w);
        model(0, 2, 0, 0, e); do_cmd(0, 2, 32'h0, 32'h0, r, lat, w);
        model(1, 1, 32'h7F7F_7F7F, 32'hFFFF_FFFF, e);
        do_cmd(1, 1, 32'h7F7F_7F7F, 32'hFFFF_FFFF, r, lat, w);
        total++; if (r !== 32'hFFFF_FC04) begin bad++; $display("FAIL mac_b1 got=%h exp=fffffc04", r); end
        model(1, 2, 32'h8080_8080, 32'h7F7F_7F7F, e);
        do_cmd(1, 2, 32'h8080_8080, 32'h7F7F_7F7F, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mac_b2 got=%h exp=0", r); end
        do_cmd(5, 1, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'hFFFF_FC04) begin bad++; $display("FAIL read_b1 got=%h exp=fffffc04", r); end
        do_cmd(5, 2, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL read_b2 got=%h exp=0", r); end
        do_cmd(5, 4, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd512) begin bad++; $display("FAIL read_b4_alias got=%h exp=200", r); end
        do_cmd(9, 1, 32'h1234_5678, 32'h1, r, lat, w);
        total++; if (r !== 32'd0 || lat !== 1) begin bad++; $display("FAIL unknown_op got=%h lat=%0d exp=0 lat=1", r, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, e, a, b;
        int lat, w;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            model(1, 3, a, b, e);
            do_cmd(1, 3, a, b, r, lat, w);
            total++; if (r !== e || lat !== 1 || (i > 0 && w !== 0)) begin
                bad++; $display("FAIL b2b_mac%0d got=%h lat=%0d waits=%0d exp=%h lat=1 waits=0", i, r, lat, w, e);
            end
        end
        model(4, 3, 0, 0, e);
        do_cmd(4, 3, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== e || lat !== 5 || w !== 0) begin
            bad++; $display("FAIL b2b_requant got=%h lat=%0d waits=%0d exp=%h lat=5 waits=0", r, lat, w, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, e, hold;
        int lat, w;
        idle(1);
        bus.rsp_ready = 1'b0;
        model(5, 1, 0, 0, e);
        do_cmd(5, 1, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== e) begin bad++; $display("FAIL bp_read got=%h exp=%h", r, e); end
        hold = e;
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = {7'd0, 3'd1};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (bus.rsp_payload_outputs_0 !== hold || bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=%h v=%b rdy=%b exp=%h v=1 rdy=0", i,
                                bus.rsp_payload_outputs_0, bus.rsp_valid, bus.cmd_ready, hold);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", bus.rsp_valid); end
        do_cmd(5, 1, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== hold) begin bad++; $display("FAIL bp_no_update got=%h exp=%h", r, hold); end
    endtask

    task automatic test_reset_mid_requant();
        logic [31:0] r;
        int lat, w;
        bit seen;
        idle(1);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = {7'd4, 3'd0};
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_state v=%b rdy=%b exp v=0 rdy=1", bus.rsp_valid, bus.cmd_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_rsp got=%b exp=0", seen); end
        do_cmd(5, 0, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL midreset_read_b0 got=%h exp=0", r); end
        do_cmd(5, 1, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL midreset_read_b1 got=%h exp=0", r); end
    endtask

    task automatic test_random();
        logic [31:0] r, e, a, b;
        int lat, w, op, bk, el;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 7);
            bk = $urandom_range(0, 7);
            a  = $urandom;
            b  = $urandom;
            if (op == 3 && $urandom_range(0, 3) != 0) b = 32'($urandom_range(0, 80)) - 32'd40;
            model(op, bk, a, b, e);
            do_cmd(op, bk, a, b, r, lat, w);
            el = (op == 4) ? 5 : 1;
            total++; if (r !== e || lat !== el) begin
                bad++; $display("FAIL rand%0d op=%0d bk=%0d got=%h lat=%0d exp=%h lat=%0d", n, op, bk, r, lat, e, el);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r, e, fin;
        int lat, w;
        model(0, 3, 0, 0, e);
        do_cmd(0, 3, 32'h0, 32'h0, r, lat, w);
        for (int n = 0; n < 16600; n++) begin
            model(1, 3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, e);
            do_cmd(1, 3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, r, lat, w);
            if (n % 100 == 99 || n > 16570) begin
                total++; if (r !== e) begin bad++; $display("FAIL ovf_mac%0d got=%h exp=%h", n, r, e); end
            end
        end
`ifdef CFU_MAC_SATURATE_EN
        fin = 32'h7FFF_FFFF;
`else
        fin = 32'(64'd129540 * 64'd16600);
`endif
        do_cmd(5, 3, 32'h0, 32'h0, r, lat, w);
        total++; if (r !== fin) begin bad++; $display("FAIL ovf_final got=%h exp=%h", r, fin); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        bus.cmd_valid               = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0    = '0;
        bus.cmd_payload_inputs_1    = '0;
        bus.rsp_ready               = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_mac_read();
        test_requant();
        test_banks();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_requant();
        test_random();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
